// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse key decoder: FSM state encoding,
// active-low 7-segment bytes {dp,g..a} and the 5-element digit codes
// (0 = dot, 1 = dash, first element in bit 4).
package morse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_GAP   = 2'd2,
      ST_OUT   = 2'd3
   } state_e;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [4:0] CODE_0 = 5'b11111;
   localparam logic [4:0] CODE_1 = 5'b01111;
   localparam logic [4:0] CODE_2 = 5'b00111;
   localparam logic [4:0] CODE_3 = 5'b00011;
   localparam logic [4:0] CODE_4 = 5'b00001;
   localparam logic [4:0] CODE_5 = 5'b00000;
   localparam logic [4:0] CODE_6 = 5'b10000;
   localparam logic [4:0] CODE_7 = 5'b11000;
   localparam logic [4:0] CODE_8 = 5'b11100;
   localparam logic [4:0] CODE_9 = 5'b11110;

   localparam logic [3:0] DIGIT_ERR = 4'hF;

   // Largest of three tick limits; sizes the shared duration counters.
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return m;
   endfunction

endpackage

// File: rtl/morse_code_to_seg.sv
// Combinational lookup from a complete 5-element Morse code to the decimal
// digit and its active-low 7-segment byte. Unknown codes report hit=0 with
// the dash glyph and the error digit.
module morse_code_to_seg
   import morse_pkg::*;
(
   input  logic [4:0] code,
   output logic       hit,
   output logic [3:0] digit,
   output logic [7:0] seg
);

   // Code table lookup; default covers every non-digit pattern.
   always_comb begin
      hit   = 1'b1;
      digit = DIGIT_ERR;
      seg   = SEG_DASH;
      case (code)
         CODE_0:  begin digit = 4'd0; seg = SEG_0; end
         CODE_1:  begin digit = 4'd1; seg = SEG_1; end
         CODE_2:  begin digit = 4'd2; seg = SEG_2; end
         CODE_3:  begin digit = 4'd3; seg = SEG_3; end
         CODE_4:  begin digit = 4'd4; seg = SEG_4; end
         CODE_5:  begin digit = 4'd5; seg = SEG_5; end
         CODE_6:  begin digit = 4'd6; seg = SEG_6; end
         CODE_7:  begin digit = 4'd7; seg = SEG_7; end
         CODE_8:  begin digit = 4'd8; seg = SEG_8; end
         CODE_9:  begin digit = 4'd9; seg = SEG_9; end
         default: begin hit = 1'b0; digit = DIGIT_ERR; seg = SEG_DASH; end
      endcase
   end

endmodule

// File: rtl/morse_key_decoder.sv
// Morse key receiver: times each press of a debounced key, classifies it as
// dot or dash, collects five elements and emits the decoded digit plus its
// active-low 7-segment byte. Incomplete codes abort after a long release.
// Optional: define MORSE_STUCK_KEY_EN to abort on a press of STUCK_TICKS.
module morse_key_decoder
   import morse_pkg::*;
#(
   parameter int unsigned LONG_TICKS  = 20_000_000,
   parameter int unsigned GAP_TICKS   = 100_000_000,
   parameter int unsigned STUCK_TICKS = 300_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       key,
   output logic [7:0] seg_x,
   output logic [3:0] digit,
   output logic       valid,
   output logic       err,
   output logic [4:0] morse_cord,
   output logic [2:0] sym_cnt
);

   localparam int unsigned MAX_TICKS = max3(LONG_TICKS, GAP_TICKS, STUCK_TICKS);
   localparam int          CNT_W     = $clog2(MAX_TICKS) + 1;

   localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_TICKS);
   localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_TICKS);
`ifdef MORSE_STUCK_KEY_EN
   localparam logic [CNT_W-1:0] STUCK_C = CNT_W'(STUCK_TICKS);
`endif

   state_e           state_q, state_d;
   logic             key_s1_q, key_s1_d;
   logic             key_s2_q, key_s2_d;
   logic             key_s3_q, key_s3_d;
   logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
   logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [7:0]       seg_x_q, seg_x_d;
   logic [3:0]       digit_q, digit_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic [4:0]       morse_cord_q, morse_cord_d;
   logic [2:0]       sym_cnt_q, sym_cnt_d;

   logic             key_rise;
   logic             key_fall;
   logic             element;
   logic             lu_hit;
   logic [3:0]       lu_digit;
   logic [7:0]       lu_seg;

   morse_code_to_seg u_lookup (
      .code  (morse_cord_q),
      .hit   (lu_hit),
      .digit (lu_digit),
      .seg   (lu_seg)
   );

   assign key_rise = key_s2_q & ~key_s3_q;
   assign key_fall = ~key_s2_q & key_s3_q;
   assign element  = (press_cnt_q >= LONG_C);

   // Next-state, counters and outputs; clr overrides everything at the end.
   always_comb begin
      state_d      = state_q;
      key_s1_d     = key;
      key_s2_d     = key_s1_q;
      key_s3_d     = key_s2_q;
      press_cnt_d  = press_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      seg_x_d      = seg_x_q;
      digit_d      = digit_q;
      valid_d      = 1'b0;
      err_d        = 1'b0;
      morse_cord_d = morse_cord_q;
      sym_cnt_d    = sym_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (key_rise) begin
               state_d     = ST_PRESS;
               press_cnt_d = CNT_W'(1);
            end
         end

         ST_PRESS: begin
            if (key_fall) begin
               morse_cord_d = {morse_cord_q[3:0], element};
               sym_cnt_d    = sym_cnt_q + 3'd1;
               if (sym_cnt_q == 3'd4) begin
                  state_d = ST_OUT;
               end else begin
                  state_d   = ST_GAP;
                  gap_cnt_d = '0;
               end
`ifdef MORSE_STUCK_KEY_EN
            end else if (press_cnt_q == STUCK_C) begin
               // Abort; the key must be released and re-pressed (IDLE ignores the fall).
               err_d        = 1'b1;
               seg_x_d      = SEG_DASH;
               digit_d      = DIGIT_ERR;
               morse_cord_d = '0;
               sym_cnt_d    = '0;
               state_d      = ST_IDLE;
`endif
            end else if (press_cnt_q != {CNT_W{1'b1}}) begin
               press_cnt_d = press_cnt_q + CNT_W'(1);
            end
         end

         ST_GAP: begin
            if (key_rise) begin
               state_d     = ST_PRESS;
               press_cnt_d = CNT_W'(1);
            end else if (gap_cnt_q == GAP_C) begin
               err_d        = 1'b1;
               seg_x_d      = SEG_DASH;
               digit_d      = DIGIT_ERR;
               morse_cord_d = '0;
               sym_cnt_d    = '0;
               state_d      = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + CNT_W'(1);
            end
         end

         ST_OUT: begin
            // A press beginning here is deliberately missed: IDLE never sees its rise.
            if (lu_hit) begin
               valid_d = 1'b1;
               seg_x_d = lu_seg;
               digit_d = lu_digit;
            end else begin
               err_d   = 1'b1;
               seg_x_d = SEG_DASH;
               digit_d = DIGIT_ERR;
            end
            morse_cord_d = '0;
            sym_cnt_d    = '0;
            state_d      = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (clr) begin
         state_d      = ST_IDLE;
         press_cnt_d  = '0;
         gap_cnt_d    = '0;
         seg_x_d      = SEG_BLANK;
         digit_d      = 4'h0;
         valid_d      = 1'b0;
         err_d        = 1'b0;
         morse_cord_d = '0;
         sym_cnt_d    = '0;
      end
   end

   // State and datapath registers. The synchronizer resets to "pressed" so a
   // key held through reset release produces no rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         key_s1_q     <= 1'b1;
         key_s2_q     <= 1'b1;
         key_s3_q     <= 1'b1;
         press_cnt_q  <= '0;
         gap_cnt_q    <= '0;
         seg_x_q      <= SEG_BLANK;
         digit_q      <= 4'h0;
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
         morse_cord_q <= '0;
         sym_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         key_s1_q     <= key_s1_d;
         key_s2_q     <= key_s2_d;
         key_s3_q     <= key_s3_d;
         press_cnt_q  <= press_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         seg_x_q      <= seg_x_d;
         digit_q      <= digit_d;
         valid_q      <= valid_d;
         err_q        <= err_d;
         morse_cord_q <= morse_cord_d;
         sym_cnt_q    <= sym_cnt_d;
      end
   end

   assign seg_x      = seg_x_q;
   assign digit      = digit_q;
   assign valid      = valid_q;
   assign err        = err_q;
   assign morse_cord = morse_cord_q;
   assign sym_cnt    = sym_cnt_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Scoreboard bench for morse_key_decoder with short tick limits
// (LONG=8, GAP=20, STUCK=50). Stimulus pushes the expected decode result,
// a monitor pops and compares on every valid/err pulse.
module tb_morse_key_decoder;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       key;
   logic [7:0] seg_x;
   logic [3:0] digit;
   logic       valid;
   logic       err;
   logic [4:0] morse_cord;
   logic [2:0] sym_cnt;

   typedef struct {
      logic       is_err;
      logic [3:0] digit;
      logic [7:0] seg;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec;
   int   n_miss;

   localparam logic [4:0] CODES [10] = '{5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001,
                                         5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110};
   localparam logic [7:0] SEGS  [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   morse_key_decoder #(
      .LONG_TICKS  (8),
      .GAP_TICKS   (20),
      .STUCK_TICKS (50)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .key        (key),
      .seg_x      (seg_x),
      .digit      (digit),
      .valid      (valid),
      .err        (err),
      .morse_cord (morse_cord),
      .sym_cnt    (sym_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic push_ok(input int d);
      exp_t e;
      e.is_err = 1'b0;
      e.digit  = 4'(d);
      e.seg    = SEGS[d];
      sb_q.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.is_err = 1'b1;
      e.digit  = 4'hF;
      e.seg    = 8'hBF;
      sb_q.push_back(e);
   endtask

   task automatic press(input int n, input int g);
      @(posedge clk); #1 key = 1'b1;
      repeat (n) @(posedge clk);
      #1 key = 1'b0;
      repeat (g) @(posedge clk);
   endtask

   task automatic send_code(input logic [4:0] c);
      for (int i = 0; i < 5; i++)
         press(c[4-i] ? 10 : 4, (i == 4) ? 12 : 5);
   endtask

   // Monitor: every output pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (rst_n && (valid || err)) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_pulse: got valid=%0b err=%0b digit=%0h seg=%0h, required no pulse",
                     valid, err, digit, seg_x);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("decode_result", {valid, err, digit, seg_x}, {~e.is_err, e.is_err, e.digit, e.seg});
         end
      end
   end

   initial begin
      logic [4:0] c;
      n_vec  = 0;
      n_miss = 0;
      rst_n  = 1'b0;
      clr    = 1'b0;
      key    = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_seg_x", seg_x, 8'hFF);
      check("reset_digit", digit, 4'h0);
      check("reset_sym_cnt", sym_cnt, 3'd0);
      check("reset_morse_cord", morse_cord, 5'd0);
      check("reset_valid", valid, 1'b0);
      check("reset_err", err, 1'b0);

      // All ten digits; partial code checked mid-way through digit 1.
      for (int d = 0; d < 10; d++) begin
         push_ok(d);
         c = CODES[d];
         for (int i = 0; i < 5; i++) begin
            press(c[4-i] ? 10 : 4, (i == 4) ? 12 : 5);
            if (d == 1 && i == 3) begin
               #1;
               check("partial_cord_d1", morse_cord, 5'b00111);
               check("partial_cnt_d1", sym_cnt, 3'd4);
            end
         end
         #1 check("held_seg", seg_x, SEGS[d]);
      end

      // Boundary: 7 cycles is a dot, 8 a dash.
      press(7, 5);
      press(8, 5);
      #1;
      check("bound_cord", morse_cord, 5'b00001);
      check("bound_cnt", sym_cnt, 3'd2);
      push_err();
      repeat (40) @(posedge clk);
      #1 check("gap_abort_cnt", sym_cnt, 3'd0);

      // Boundary in a full code: 8,7,7,7,7 -> 10000 = 6.
      push_ok(6);
      press(8, 5); press(7, 5); press(7, 5); press(7, 5); press(7, 12);

      // Two dots then long release -> gap timeout.
      push_err();
      press(4, 5);
      press(4, 40);
      #1;
      check("gap_seg", seg_x, 8'hBF);
      check("gap_digit", digit, 4'hF);
      check("gap_sym_cnt", sym_cnt, 3'd0);
      check("gap_cord", morse_cord, 5'd0);

      // Invalid code then recovery with 0.
      push_err();
      send_code(5'b01010);
      push_ok(0);
      send_code(5'b11111);
      #1 check("recover_seg", seg_x, 8'hC0);

      // clr in the cycle of the 5th falling-edge detection.
      press(10, 5); press(10, 5); press(4, 5); press(4, 5);
      @(posedge clk); #1 key = 1'b1;
      repeat (4) @(posedge clk);
      #1 key = 1'b0;
      repeat (2) @(posedge clk);
      #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("clr_seg", seg_x, 8'hFF);
      check("clr_digit", digit, 4'h0);
      check("clr_sym_cnt", sym_cnt, 3'd0);

      // Key held across clr is ignored until re-pressed.
      push_ok(3);
      press(4, 5);
      @(posedge clk); #1 key = 1'b1;
      repeat (6) @(posedge clk);
      #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      repeat (6) @(posedge clk);
      #1 key = 1'b0;
      repeat (10) @(posedge clk);
      #1 check("held_clr_cnt", sym_cnt, 3'd0);
      send_code(CODES[3]);

`ifdef MORSE_STUCK_KEY_EN
      // Stuck key aborts at 50 cycles; its release is ignored.
      push_err();
      press(60, 10);
      #1 check("stuck_cnt", sym_cnt, 3'd0);
      push_ok(9);
      send_code(CODES[9]);
`else
      // Without stuck detection a very long press is simply a dash.
      push_ok(0);
      press(60, 5); press(10, 5); press(10, 5); press(10, 5); press(10, 12);
`endif

      repeat (20) @(posedge clk);
      #1 check("scoreboard_drained", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
